// File: rtl/puf_response_collector.sv
// PUF response collector: drives the race arbiter through repeated
// arm/fire/sample evaluations, majority-votes VOTES samples per challenge
// bit, assembles an RESP_W-bit response and offers it on a valid/ready port.
// Also counts how many bits had non-unanimous votes.
//
// Handshake: o_resp_valid is high only in DONE and stays high, with
// o_resp_data/o_unstable_cnt stable, until a cycle where i_resp_ready is
// also high; that edge completes the transfer and the FSM returns to IDLE.
module puf_response_collector #(
    parameter int RESP_W = 16,
    parameter int VOTES  = 5,
    parameter int SETTLE = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    output logic                        o_arb_enable,
    input  logic                        i_arb_out,
    output logic [$clog2(RESP_W)-1:0]   o_bit_idx,
    output logic                        o_busy,
    output logic [RESP_W-1:0]           o_resp_data,
    output logic                        o_resp_valid,
    input  logic                        i_resp_ready,
    output logic [$clog2(RESP_W+1)-1:0] o_unstable_cnt,
    output logic [2:0]                  o_dbg_state
);

    localparam int BW = $clog2(RESP_W);
    localparam int CW = $clog2(RESP_W + 1);
    localparam int VW = $clog2(VOTES + 1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_FIRE   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [SW-1:0]       r_settle_cnt;
    logic [VW-1:0]       r_votes;
    logic [VW-1:0]       r_ones;
    logic [BW-1:0]       r_bit_idx;
    logic [RESP_W-1:0]   r_resp_data;
    logic [CW-1:0]       r_unstable_cnt;

    logic [VW-1:0]       w_votes_inc;
    logic [VW-1:0]       w_ones_inc;
    logic                w_vote_last;
    logic                w_bit_last;
    logic                w_settle_last;
    logic                w_bit_val;
    logic                w_unanimous;

    // Vote arithmetic for the current SAMPLE cycle (counts include this sample).
    always_comb begin
        w_votes_inc   = r_votes + VW'(1);
        w_ones_inc    = r_ones + VW'(i_arb_out);
        w_vote_last   = (w_votes_inc >= VW'(VOTES));
        w_bit_last    = (r_bit_idx == BW'(RESP_W - 1));
        w_settle_last = (r_settle_cnt == SW'(SETTLE - 1));
        w_bit_val     = (w_ones_inc > VW'(VOTES / 2));
        w_unanimous   = (w_ones_inc == '0) || (w_ones_inc == VW'(VOTES));
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_ARM;
            S_ARM:    w_next = S_FIRE;
            S_FIRE:   if (w_settle_last) w_next = S_SAMPLE;
            S_SAMPLE: begin
                if (w_vote_last && w_bit_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_ARM;
                end
            end
            S_DONE:   if (i_resp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath: settle timing, vote accumulation, bit resolution.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_settle_cnt   <= '0;
            r_votes        <= '0;
            r_ones         <= '0;
            r_bit_idx      <= '0;
            r_resp_data    <= '0;
            r_unstable_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_settle_cnt <= '0;
                    if (i_start) begin
                        r_votes        <= '0;
                        r_ones         <= '0;
                        r_bit_idx      <= '0;
                        r_resp_data    <= '0;
                        r_unstable_cnt <= '0;
                    end
                end
                S_ARM: begin
                    r_settle_cnt <= '0;
                end
                S_FIRE: begin
                    r_settle_cnt <= r_settle_cnt + SW'(1);
                end
                S_SAMPLE: begin
                    if (!w_vote_last) begin
                        r_votes <= w_votes_inc;
                        r_ones  <= w_ones_inc;
                    end else begin
                        r_resp_data[r_bit_idx] <= w_bit_val;
                        if (!w_unanimous) begin
                            r_unstable_cnt <= r_unstable_cnt + CW'(1);
                        end
                        r_votes <= '0;
                        r_ones  <= '0;
                        // bit_idx holds at RESP_W-1 through DONE.
                        if (!w_bit_last) begin
                            r_bit_idx <= r_bit_idx + BW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_arb_enable   = (r_state == S_FIRE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_resp_valid   = (r_state == S_DONE);
    assign o_bit_idx      = r_bit_idx;
    assign o_resp_data    = r_resp_data;
    assign o_unstable_cnt = r_unstable_cnt;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_puf_response_collector.sv
// Directed bench for puf_response_collector with RESP_W=4, VOTES=3, SETTLE=2.
// An arbiter stand-in supplies one arb_out value per evaluation (inverted
// outside SAMPLE so stray sampling shows up); a majority model fills the
// expected-response queue when each run is launched.
module tb_puf_response_collector;

  localparam int RW = 4;
  localparam int NV = 3;
  localparam int ST = 2;
  localparam int EV = RW * NV;
  localparam int EC = ST + 2;

  logic          i_clk;
  logic          i_rst;
  logic          i_start;
  logic          o_arb_enable;
  logic          i_arb_out;
  logic [1:0]    o_bit_idx;
  logic          o_busy;
  logic [RW-1:0] o_resp_data;
  logic          o_resp_valid;
  logic          i_resp_ready;
  logic [2:0]    o_unstable_cnt;
  logic [2:0]    o_dbg_state;

  logic [RW-1:0] exp_q[$];
  logic [2:0]    exp_u_q[$];
  logic [RW-1:0] last_d;
  logic [2:0]    last_u;
  int            n_vec;
  int            n_fail;
  bit            aborted;

  puf_response_collector #(.RESP_W(RW), .VOTES(NV), .SETTLE(ST)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .o_arb_enable   (o_arb_enable),
    .i_arb_out      (i_arb_out),
    .o_bit_idx      (o_bit_idx),
    .o_busy         (o_busy),
    .o_resp_data    (o_resp_data),
    .o_resp_valid   (o_resp_valid),
    .i_resp_ready   (i_resp_ready),
    .o_unstable_cnt (o_unstable_cnt),
    .o_dbg_state    (o_dbg_state)
  );

  // clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_arb_en"}, 32'(o_arb_enable), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_bit_idx"}, 32'(o_bit_idx), 32'd0);
    chk({tag, "_valid"}, 32'(o_resp_valid), 32'd0);
    chk({tag, "_data"}, 32'(o_resp_data), 32'd0);
    chk({tag, "_unstable"}, 32'(o_unstable_cnt), 32'd0);
  endtask

  // One complete run: seq[e] is the arbiter result for evaluation e.
  // start_c / rst_c inject a start pulse or a reset in that cycle (-1 = none).
  task automatic run(input logic [EV-1:0] seq, input int start_c, input int rst_c,
                     output bit was_aborted);
    logic [RW-1:0] exp_d;
    logic [2:0]    exp_u;
    int            ones;
    int            e;
    int            p;
    exp_d = '0;
    exp_u = '0;
    for (int b = 0; b < RW; b++) begin
      ones = 0;
      for (int v = 0; v < NV; v++) ones += int'(seq[b*NV+v]);
      exp_d[b] = (ones > NV / 2);
      if (ones != 0 && ones != NV) exp_u++;
    end
    exp_q.push_back(exp_d);
    exp_u_q.push_back(exp_u);
    was_aborted = 1'b0;

    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int c = 0; c < EV * EC; c++) begin
      e = c / EC;
      p = c % EC;
      i_arb_out = (p == EC - 1) ? seq[e] : ~seq[e];
      i_start = (c == start_c);
      if (c == rst_c) begin
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        i_start = 1'b0;
        chk_idle_reset("abort");
        void'(exp_q.pop_back());
        void'(exp_u_q.pop_back());
        was_aborted = 1'b1;
        return;
      end
      if (c == 0) begin
        chk("entry_data_clear", 32'(o_resp_data), 32'd0);
        chk("entry_unstable_clear", 32'(o_unstable_cnt), 32'd0);
      end
      chk("arb_enable", 32'(o_arb_enable), 32'(p >= 1 && p <= ST));
      chk("bit_idx", 32'(o_bit_idx), 32'(e / NV));
      chk("busy_run", 32'(o_busy), 32'd1);
      chk("valid_run", 32'(o_resp_valid), 32'd0);
      @(negedge i_clk);
    end
    i_start = 1'b0;

    // exactly EV*EC cycles after the first ARM cycle
    chk("valid_latency", 32'(o_resp_valid), 32'd1);
    chk("done_state", 32'(o_dbg_state), 32'd4);
    chk("done_bit_idx", 32'(o_bit_idx), 32'(RW - 1));
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      last_d = exp_q.pop_front();
      last_u = exp_u_q.pop_front();
      chk("resp_data", 32'(o_resp_data), 32'(last_d));
      chk("unstable_cnt", 32'(o_unstable_cnt), 32'(last_u));
    end
  endtask

  // Hold off ready in DONE, then accept (optionally with start also high).
  task automatic handshake(input int hold, input logic with_start);
    for (int i = 0; i < hold; i++) begin
      i_resp_ready = 1'b0;
      i_start = (with_start && i == hold / 2);
      chk("hold_valid", 32'(o_resp_valid), 32'd1);
      chk("hold_data", 32'(o_resp_data), 32'(last_d));
      chk("hold_unstable", 32'(o_unstable_cnt), 32'(last_u));
      chk("hold_arb_en", 32'(o_arb_enable), 32'd0);
      @(negedge i_clk);
    end
    i_resp_ready = 1'b1;
    i_start = with_start;
    @(negedge i_clk);
    i_resp_ready = 1'b0;
    i_start = 1'b0;
    chk("accept_valid", 32'(o_resp_valid), 32'd0);
    chk("accept_busy", 32'(o_busy), 32'd0);
    chk("idle_data_kept", 32'(o_resp_data), 32'(last_d));
    chk("idle_unstable_kept", 32'(o_unstable_cnt), 32'(last_u));
    repeat (3) @(negedge i_clk);
    chk("idle_stays", 32'(o_busy), 32'd0);
    chk("idle_arb_en", 32'(o_arb_enable), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    last_d = '0;
    last_u = '0;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_arb_out = 1'b0;
    i_resp_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    chk_idle_reset("reset");

    // arbiter stuck at 1: all ones, no unstable bits
    run(12'hFFF, -1, -1, aborted);
    handshake(10, 1'b0);

    // mixed votes; start pulsed in FIRE of bit 2 and again with ready in DONE
    run(12'h625, 2 * NV * EC + 1, -1, aborted);
    handshake(10, 1'b1);

    // fresh start in IDLE clears the previous response on entry
    run(12'($urandom_range(0, 4095)), -1, -1, aborted);
    handshake(3, 1'b0);

    // reset during FIRE of bit 1 (bit 0 already resolved to 1)
    run(12'hFFF, -1, 1 * NV * EC + 1, aborted);
    chk("abort_taken", 32'(aborted), 32'd1);
    repeat (3) @(negedge i_clk);
    chk_idle_reset("after_abort");

    run(12'h000, -1, -1, aborted);
    handshake(2, 1'b0);

    for (int k = 0; k < 2; k++) begin
      run(12'($urandom_range(0, 4095)), -1, -1, aborted);
      handshake($urandom_range(0, 4), 1'b0);
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
